// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
// Purpose: one req/gnt/rvalid memory port bundle, used for both cache-side
//          ports and the shared memory-side port of cache_mem_arbiter.
// Handshake: the requester raises req with addr/wdata/we/be valid and holds
//   them until the responder returns gnt in the same cycle (zero-latency
//   accept). Exactly one rvalid pulse follows each grant. rdata/error are
//   meaningful only while rvalid=1. Only one transaction is in flight at a
//   time.
// Signals:
//   req    requester -> responder  transaction request
//   addr   requester -> responder  32-bit word address
//   wdata  requester -> responder  32-bit write data
//   we     requester -> responder  write enable
//   be     requester -> responder  4-bit byte enables
//   gnt    responder -> requester  request accepted
//   rvalid responder -> requester  response valid
//   rdata  responder -> requester  32-bit read data
//   error  responder -> requester  response error
// Modports: master = requester side, slave = responder side.
interface cache_mem_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        error;

  modport master (
    output req, addr, wdata, we, be,
    input  gnt, rvalid, rdata, error
  );

  modport slave (
    input  req, addr, wdata, we, be,
    output gnt, rvalid, rdata, error
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Purpose: arbitrates the instruction-cache (m0) and data-cache (m1) memory
//   ports onto one memory port, one transaction in flight at a time.
//   Round-robin (or fixed m0 priority) on ties; a request that is presented
//   but not yet granted locks the selection; a stuck memory is caught by a
//   response timeout.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous reset, active-high
//   m0, m1   slave modport   cache-side ports
//   mem      master modport  memory-side port
//   o_state  out  FSM state (0 = IDLE, 1 = WAIT) for observation
module cache_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_mem_arbiter_if.slave   m0,
  cache_mem_arbiter_if.slave   m1,
  cache_mem_arbiter_if.master  mem,
  output logic                 o_state
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner;
  logic          r_locked;
  logic          r_last;
  logic [TW-1:0] r_tmo_ctr;

  logic          w_sel;
  logic          w_req_sel;
  logic          w_tmo_hit;

  assign o_state = r_state;

  // Master selection; a pending ungranted request keeps its slot so the
  // memory never sees the address change under an outstanding req.
  always_comb begin
    w_sel = 1'b0;
    if (r_locked)              w_sel = r_owner;
    else if (m0.req && !m1.req) w_sel = 1'b0;
    else if (!m0.req && m1.req) w_sel = 1'b1;
    else if (m0.req && m1.req)  w_sel = FIXED_PRIORITY ? 1'b0 : ~r_last;
  end

  assign w_req_sel = w_sel ? m1.req : m0.req;

  // Timeout fires only when no real response arrives that cycle.
  assign w_tmo_hit = (TIMEOUT_CYCLES > 0) && (r_state == S_WAIT) &&
                     (r_tmo_ctr == TMO_LAST) && !mem.rvalid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Arbitration bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner   <= 1'b0;
      r_locked  <= 1'b0;
      r_last    <= 1'b1;
      r_tmo_ctr <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_req_sel) begin
        r_owner <= w_sel;
        if (mem.gnt) begin
          r_last    <= w_sel;
          r_locked  <= 1'b0;
          r_tmo_ctr <= '0;
        end else begin
          r_locked <= 1'b1;
        end
      end
    end else if (TIMEOUT_CYCLES > 0) begin
      r_tmo_ctr <= r_tmo_ctr + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_sel && mem.gnt) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem.rvalid || w_tmo_hit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; everything not explicitly driven stays zero, so the
  // non-owner master never sees gnt/rvalid/error/rdata.
  always_comb begin
    mem.req   = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    mem.we    = 1'b0;
    mem.be    = '0;
    m0.gnt    = 1'b0;
    m0.rvalid = 1'b0;
    m0.rdata  = '0;
    m0.error  = 1'b0;
    m1.gnt    = 1'b0;
    m1.rvalid = 1'b0;
    m1.rdata  = '0;
    m1.error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_sel) begin
          mem.req   = 1'b1;
          mem.addr  = w_sel ? m1.addr  : m0.addr;
          mem.wdata = w_sel ? m1.wdata : m0.wdata;
          mem.we    = w_sel ? m1.we    : m0.we;
          mem.be    = w_sel ? m1.be    : m0.be;
          if (mem.gnt) begin
            if (w_sel) m1.gnt = 1'b1;
            else       m0.gnt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Real response wins over a coincident timeout.
        if (mem.rvalid || w_tmo_hit) begin
          if (r_owner) begin
            m1.rvalid = 1'b1;
            m1.rdata  = mem.rvalid ? mem.rdata : 32'h0;
            m1.error  = mem.rvalid ? mem.error : 1'b1;
          end else begin
            m0.rvalid = 1'b1;
            m0.rdata  = mem.rvalid ? mem.rdata : 32'h0;
            m0.error  = mem.rvalid ? mem.error : 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  logic clk;
  logic reset;
  logic a_state;
  logic b_state;
  int   checks;
  int   errors;

  cache_mem_arbiter_if a_m0 ();
  cache_mem_arbiter_if a_m1 ();
  cache_mem_arbiter_if a_mem ();
  cache_mem_arbiter_if b_m0 ();
  cache_mem_arbiter_if b_m1 ();
  cache_mem_arbiter_if b_mem ();

  // Round-robin instance with a short timeout
  cache_mem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset), .m0(a_m0), .m1(a_m1), .mem(a_mem), .o_state(a_state)
  );

  // Fixed-priority instance
  cache_mem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .m0(b_m0), .m1(b_m1), .mem(b_mem), .o_state(b_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic idle_inputs();
    a_m0.req = 0; a_m0.addr = 0; a_m0.wdata = 0; a_m0.we = 0; a_m0.be = 0;
    a_m1.req = 0; a_m1.addr = 0; a_m1.wdata = 0; a_m1.we = 0; a_m1.be = 0;
    a_mem.gnt = 0; a_mem.rvalid = 0; a_mem.rdata = 0; a_mem.error = 0;
    b_m0.req = 0; b_m0.addr = 0; b_m0.wdata = 0; b_m0.we = 0; b_m0.be = 0;
    b_m1.req = 0; b_m1.addr = 0; b_m1.wdata = 0; b_m1.we = 0; b_m1.be = 0;
    b_mem.gnt = 0; b_mem.rvalid = 0; b_mem.rdata = 0; b_mem.error = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    #1;
    checks++; if (a_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0b expected 0", a_state); end
    checks++; if (a_mem.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", a_mem.req); end
    checks++; if (a_mem.addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", a_mem.addr); end
    checks++; if ({a_m0.gnt, a_m0.rvalid, a_m0.error, a_m1.gnt, a_m1.rvalid, a_m1.error} !== 6'b0) begin
      errors++; $display("FAIL reset_master_flags: got %b expected 000000", {a_m0.gnt, a_m0.rvalid, a_m0.error, a_m1.gnt, a_m1.rvalid, a_m1.error});
    end
    checks++; if (a_m0.rdata !== 32'h0 || a_m1.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", a_m0.rdata, a_m1.rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_tie_rr();
    logic [3:0] exp_m1;
    exp_m1 = 4'b1010; // round i: bit i = expected m1 grant
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      a_m0.req = 1; a_m1.req = 1; a_m0.addr = 32'h10 + i; a_m1.addr = 32'h20 + i; a_mem.gnt = 1;
      #1;
      checks++; if ({a_m1.gnt, a_m0.gnt} !== {exp_m1[i], ~exp_m1[i]}) begin
        errors++; $display("FAIL tie_rr_round%0d: got m1,m0 gnt=%b%b expected %b%b", i, a_m1.gnt, a_m0.gnt, exp_m1[i], ~exp_m1[i]);
      end
      tick();
      a_m0.req = 0; a_m1.req = 0; a_mem.gnt = 0; a_mem.rvalid = 1; a_mem.rdata = 32'hC0 + i;
      #1;
      checks++; if ((exp_m1[i] ? a_m1.rdata : a_m0.rdata) !== 32'hC0 + i) begin
        errors++; $display("FAIL tie_rr_rdata%0d: got m0=%h m1=%h expected %h to winner", i, a_m0.rdata, a_m1.rdata, 32'hC0 + i);
      end
      tick();
      a_mem.rvalid = 0; a_mem.rdata = 0;
    end
  endtask

  task automatic test_tie_fixed();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      b_m0.req = 1; b_m1.req = 1; b_mem.gnt = 1;
      #1;
      checks++; if ({b_m1.gnt, b_m0.gnt} !== 2'b01) begin
        errors++; $display("FAIL tie_fixed_round%0d: got m1,m0 gnt=%b%b expected 01", i, b_m1.gnt, b_m0.gnt);
      end
      tick();
      b_mem.gnt = 0; b_mem.rvalid = 1;
      tick();
      b_mem.rvalid = 0;
    end
    b_m0.req = 0; b_m1.req = 1; b_mem.gnt = 1;
    #1;
    checks++; if ({b_m1.gnt, b_m0.gnt} !== 2'b10) begin
      errors++; $display("FAIL tie_fixed_m1_alone: got m1,m0 gnt=%b%b expected 10", b_m1.gnt, b_m0.gnt);
    end
    tick();
    b_m1.req = 0; b_mem.gnt = 0; b_mem.rvalid = 1;
    tick();
    b_mem.rvalid = 0;
  endtask

  task automatic test_single_read();
    pulse_reset();
    a_m0.req = 1; a_m0.addr = 32'h100; a_mem.gnt = 1;
    #1;
    checks++; if (a_m0.gnt !== 1'b1) begin errors++; $display("FAIL single_m0_gnt: got %0b expected 1", a_m0.gnt); end
    checks++; if (a_mem.req !== 1'b1 || a_mem.addr !== 32'h100) begin
      errors++; $display("FAIL single_mem_req: got req=%0b addr=%h expected 1/00000100", a_mem.req, a_mem.addr);
    end
    tick();
    a_m0.req = 0; a_m0.addr = 0; a_mem.gnt = 0;
    #1;
    checks++; if (a_state !== 1'b1 || a_mem.req !== 1'b0 || a_m0.rvalid !== 1'b0) begin
      errors++; $display("FAIL single_wait: got state=%0b mem_req=%0b rvalid=%0b expected 1/0/0", a_state, a_mem.req, a_m0.rvalid);
    end
    tick();
    a_mem.rvalid = 1; a_mem.rdata = 32'hDEADBEEF;
    #1;
    checks++; if (a_m0.rvalid !== 1'b1 || a_m0.rdata !== 32'hDEADBEEF || a_m0.error !== 1'b0) begin
      errors++; $display("FAIL single_resp: got rvalid=%0b rdata=%h err=%0b expected 1/deadbeef/0", a_m0.rvalid, a_m0.rdata, a_m0.error);
    end
    checks++; if ({a_m1.gnt, a_m1.rvalid, a_m1.error} !== 3'b0 || a_m1.rdata !== 32'h0) begin
      errors++; $display("FAIL single_m1_quiet: got flags=%b rdata=%h expected 000/0", {a_m1.gnt, a_m1.rvalid, a_m1.error}, a_m1.rdata);
    end
    tick();
    a_mem.rvalid = 0; a_mem.rdata = 0;
    #1;
    checks++; if (a_state !== 1'b0 || a_m0.rvalid !== 1'b0) begin
      errors++; $display("FAIL single_back_idle: got state=%0b rvalid=%0b expected 0/0", a_state, a_m0.rvalid);
    end
  endtask

  task automatic test_lock();
    tick();
    a_m1.req = 1; a_m1.addr = 32'h200; a_mem.gnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin a_m0.req = 1; a_m0.addr = 32'h300; end
      #1;
      checks++; if (a_mem.addr !== 32'h200 || a_m0.gnt !== 1'b0 || a_m1.gnt !== 1'b0) begin
        errors++; $display("FAIL lock_hold_c%0d: got addr=%h gnt m0/m1=%b%b expected 00000200/00", c, a_mem.addr, a_m0.gnt, a_m1.gnt);
      end
      tick();
    end
    a_mem.gnt = 1;
    #1;
    checks++; if (a_m1.gnt !== 1'b1 || a_m0.gnt !== 1'b0 || a_mem.addr !== 32'h200) begin
      errors++; $display("FAIL lock_grant_m1: got gnt m1/m0=%b%b addr=%h expected 10/00000200", a_m1.gnt, a_m0.gnt, a_mem.addr);
    end
    tick();
    a_m1.req = 0; a_mem.gnt = 0; a_mem.rvalid = 1; a_mem.rdata = 32'h2222;
    #1;
    checks++; if (a_m1.rvalid !== 1'b1 || a_m1.rdata !== 32'h2222 || a_m0.rvalid !== 1'b0) begin
      errors++; $display("FAIL lock_resp_m1: got m1 rvalid=%0b rdata=%h m0 rvalid=%0b expected 1/2222/0", a_m1.rvalid, a_m1.rdata, a_m0.rvalid);
    end
    tick();
    a_mem.rvalid = 0; a_mem.rdata = 0; a_mem.gnt = 1;
    #1;
    checks++; if (a_m0.gnt !== 1'b1 || a_mem.addr !== 32'h300) begin
      errors++; $display("FAIL lock_grant_m0_next: got gnt=%0b addr=%h expected 1/00000300", a_m0.gnt, a_mem.addr);
    end
    tick();
    a_m0.req = 0; a_m0.addr = 0; a_mem.gnt = 0; a_mem.rvalid = 1;
    tick();
    a_mem.rvalid = 0;
  endtask

  task automatic test_timeout();
    tick();
    a_m0.req = 1; a_m0.addr = 32'h44; a_mem.gnt = 1;
    #1;
    checks++; if (a_m0.gnt !== 1'b1) begin errors++; $display("FAIL tmo_grant: got %0b expected 1", a_m0.gnt); end
    tick();
    a_m0.req = 0; a_mem.gnt = 0; a_mem.rdata = 32'h55;
    for (int c = 1; c < 8; c++) begin
      #1;
      checks++; if (a_m0.rvalid !== 1'b0 || a_state !== 1'b1) begin
        errors++; $display("FAIL tmo_early_c%0d: got rvalid=%0b state=%0b expected 0/1", c, a_m0.rvalid, a_state);
      end
      tick();
    end
    #1;
    checks++; if (a_m0.rvalid !== 1'b1 || a_m0.error !== 1'b1 || a_m0.rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_fire: got rvalid=%0b err=%0b rdata=%h expected 1/1/0", a_m0.rvalid, a_m0.error, a_m0.rdata);
    end
    tick();
    a_mem.rvalid = 1; a_mem.error = 1;
    #1;
    checks++; if ({a_m0.rvalid, a_m0.error, a_m1.rvalid, a_m1.error} !== 4'b0 || a_state !== 1'b0) begin
      errors++; $display("FAIL tmo_stray_ignored: got flags=%b state=%0b expected 0000/0", {a_m0.rvalid, a_m0.error, a_m1.rvalid, a_m1.error}, a_state);
    end
    tick();
    a_mem.rvalid = 0; a_mem.error = 0; a_mem.rdata = 0;
  endtask

  task automatic test_write_passthrough();
    tick();
    a_m1.req = 1; a_m1.we = 1; a_m1.be = 4'b0011; a_m1.wdata = 32'h12345678; a_m1.addr = 32'h40; a_mem.gnt = 1;
    #1;
    checks++; if (a_mem.we !== 1'b1 || a_mem.be !== 4'b0011 || a_mem.wdata !== 32'h12345678 || a_mem.addr !== 32'h40) begin
      errors++; $display("FAIL write_fields: got we=%0b be=%b wdata=%h addr=%h expected 1/0011/12345678/00000040", a_mem.we, a_mem.be, a_mem.wdata, a_mem.addr);
    end
    checks++; if (a_m1.gnt !== 1'b1) begin errors++; $display("FAIL write_gnt: got %0b expected 1", a_m1.gnt); end
    tick();
    a_m1.req = 0; a_m1.we = 0; a_m1.be = 0; a_m1.wdata = 0; a_m1.addr = 0; a_mem.gnt = 0;
    tick();
    a_mem.rvalid = 1; a_mem.error = 1;
    #1;
    checks++; if (a_m1.rvalid !== 1'b1 || a_m1.error !== 1'b1 || a_m0.error !== 1'b0) begin
      errors++; $display("FAIL write_error: got m1 rvalid=%0b err=%0b m0 err=%0b expected 1/1/0", a_m1.rvalid, a_m1.error, a_m0.error);
    end
    tick();
    a_mem.rvalid = 0; a_mem.error = 0;
  endtask

  task automatic test_reset_in_wait();
    tick();
    a_m0.req = 1; a_mem.gnt = 1;
    tick();
    a_m0.req = 0; a_mem.gnt = 0;
    #1;
    checks++; if (a_state !== 1'b1) begin errors++; $display("FAIL rst_wait_entered: got %0b expected 1", a_state); end
    reset = 1'b1;
    #1;
    checks++; if (a_state !== 1'b0 || a_mem.req !== 1'b0 || a_m0.rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_async_clear: got state=%0b mem_req=%0b rvalid=%0b expected 0/0/0", a_state, a_mem.req, a_m0.rvalid);
    end
    tick();
    reset = 1'b0;
    a_mem.rvalid = 1; a_mem.rdata = 32'hBAD;
    #1;
    checks++; if (a_m0.rvalid !== 1'b0 || a_m0.rdata !== 32'h0) begin
      errors++; $display("FAIL rst_dropped_resp: got rvalid=%0b rdata=%h expected 0/0", a_m0.rvalid, a_m0.rdata);
    end
    tick();
    a_mem.rvalid = 0; a_mem.rdata = 0;
    a_m0.req = 1; a_m1.req = 1; a_mem.gnt = 1;
    #1;
    checks++; if ({a_m1.gnt, a_m0.gnt} !== 2'b01) begin
      errors++; $display("FAIL rst_tie_m0: got m1,m0 gnt=%b%b expected 01", a_m1.gnt, a_m0.gnt);
    end
    tick();
    a_m0.req = 0; a_m1.req = 0; a_mem.gnt = 0; a_mem.rvalid = 1;
    tick();
    a_mem.rvalid = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_tie_rr();
    test_tie_fixed();
    test_single_read();
    test_lock();
    test_timeout();
    test_write_passthrough();
    test_reset_in_wait();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
